note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_note_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - eight-step song sequencer with tempo ticks, gaps, looping and manual key override
module note_sequencer #(
    parameter int unsigned TICK_DIV = 12500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play_start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [11:0] key_req,
    output logic [11:0] freq_out,
    output logic        src_key,
    output logic        busy,
    output logic [2:0]  step_idx,
    output logic        note_strobe
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

    // Note indices 12..15 are rests and map to silence.
    function automatic logic [11:0] note_freq(input logic [3:0] n);
        logic [11:0] f;
        case (n)
            4'd0:    f = 12'd261;
            4'd1:    f = 12'd277;
            4'd2:    f = 12'd293;
            4'd3:    f = 12'd311;
            4'd4:    f = 12'd330;
            4'd5:    f = 12'd349;
            4'd6:    f = 12'd370;
            4'd7:    f = 12'd392;
            4'd8:    f = 12'd415;
            4'd9:    f = 12'd440;
            4'd10:   f = 12'd466;
            4'd11:   f = 12'd494;
            default: f = 12'd0;
        endcase
        return f;
    endfunction

    function automatic logic [7:0] song_rom(input logic [2:0] idx);
        logic [7:0] e;
        case (idx)
            3'd0:    e = {4'd0,  4'd2};
            3'd1:    e = {4'd2,  4'd2};
            3'd2:    e = {4'd4,  4'd2};
            3'd3:    e = {4'd5,  4'd2};
            3'd4:    e = {4'd7,  4'd2};
            3'd5:    e = {4'd9,  4'd2};
            3'd6:    e = {4'd11, 4'd4};
            default: e = {4'd12, 4'd1};
        endcase
        return e;
    endfunction

    function automatic logic [3:0] step_note(input logic [2:0] idx);
        logic [7:0] e;
        e = song_rom(idx);
        return e[7:4];
    endfunction

    function automatic logic [3:0] step_dur(input logic [2:0] idx);
        logic [7:0] e;
        e = song_rom(idx);
        return (e[3:0] == 4'd0) ? 4'd1 : e[3:0];
    endfunction

    // Lowest set key wins, so scan from the top and let lower bits overwrite.
    function automatic logic [11:0] key_freq(input logic [11:0] k);
        logic [11:0] f;
        f = 12'd0;
        for (int i = 11; i >= 0; i--) begin
            if (k[i]) f = note_freq(4'(i));
        end
        return f;
    endfunction

    state_t      state_q, state_d;
    logic [23:0] tick_q, tick_d;
    logic [3:0]  rem_q, rem_d;
    logic [2:0]  step_q, step_d;
    logic [11:0] freq_q, freq_d;
    logic        src_q, src_d;
    logic        busy_q, busy_d;
    logic        strobe_q, strobe_d;

    logic        key_active;
    logic        tick_end;

    assign key_active = |key_req;
    assign tick_end   = (tick_q == TICK_LAST);

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        rem_d    = rem_q;
        step_d   = step_q;
        strobe_d = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            step_d  = 3'd0;
            tick_d  = 24'd0;
            rem_d   = 4'd0;
        end else if (!key_active) begin
            case (state_q)
                S_IDLE: begin
                    if (play_start) begin
                        state_d  = S_PLAY;
                        step_d   = 3'd0;
                        tick_d   = 24'd0;
                        rem_d    = step_dur(3'd0);
                        strobe_d = (step_note(3'd0) < 4'd12);
                    end
                end
                S_PLAY: begin
                    if (tick_end) begin
                        tick_d = 24'd0;
                        if (rem_q <= 4'd1) begin
                            state_d = S_GAP;
                            rem_d   = 4'd0;
                        end else begin
                            rem_d = rem_q - 4'd1;
                        end
                    end else begin
                        tick_d = tick_q + 24'd1;
                    end
                end
                S_GAP: begin
                    if (tick_end) begin
                        tick_d = 24'd0;
                        if (step_q == 3'd7 && !loop_en) begin
                            state_d = S_IDLE;
                            step_d  = 3'd0;
                        end else begin
                            state_d  = S_PLAY;
                            step_d   = step_q + 3'd1;
                            rem_d    = step_dur(step_q + 3'd1);
                            strobe_d = (step_note(step_q + 3'd1) < 4'd12);
                        end
                    end else begin
                        tick_d = tick_q + 24'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    step_d  = 3'd0;
                    tick_d  = 24'd0;
                    rem_d   = 4'd0;
                end
            endcase
        end

        if (key_active) begin
            freq_d = key_freq(key_req);
            src_d  = 1'b1;
        end else begin
            freq_d = (state_d == S_PLAY) ? note_freq(step_note(step_d)) : 12'd0;
            src_d  = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tick_q   <= 24'd0;
            rem_q    <= 4'd0;
            step_q   <= 3'd0;
            freq_q   <= 12'd0;
            src_q    <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            rem_q    <= rem_d;
            step_q   <= step_d;
            freq_q   <= freq_d;
            src_q    <= src_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
        end
    end

    assign freq_out    = freq_q;
    assign src_key     = src_q;
    assign busy        = busy_q;
    assign step_idx    = step_q;
    assign note_strobe = strobe_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed bench for note_sequencer with a song-position reference model
module tb_note_sequencer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        play_start;
    logic        stop;
    logic        loop_en;
    logic [11:0] key_req;
    logic [11:0] freq_out;
    logic        src_key;
    logic        busy;
    logic [2:0]  step_idx;
    logic        note_strobe;

    note_sequencer #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .play_start  (play_start),
        .stop        (stop),
        .loop_en     (loop_en),
        .key_req     (key_req),
        .freq_out    (freq_out),
        .src_key     (src_key),
        .busy        (busy),
        .step_idx    (step_idx),
        .note_strobe (note_strobe)
    );

    always #5 clk = ~clk;

    int note_tab [8]  = '{0, 2, 4, 5, 7, 9, 11, 12};
    int dur_tab  [8]  = '{2, 2, 2, 2, 2, 2, 4, 1};
    int freq_tab [16] = '{261, 277, 293, 311, 330, 349, 370, 392,
                          415, 440, 466, 494, 0, 0, 0, 0};

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Song position: unpaused cycles since the current playback started.
    int pos = 0;
    bit playing = 1'b0;
    int e_freq, e_src, e_busy, e_step, e_strobe;

    function automatic int song_len();
        int s = 0;
        for (int i = 0; i < 8; i++) s += (dur_tab[i] + 1) * TD;
        return s;
    endfunction

    function automatic int step_of(input int p);
        int acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (p < acc + (dur_tab[i] + 1) * TD) return i;
            acc += (dur_tab[i] + 1) * TD;
        end
        return 7;
    endfunction

    function automatic int off_of(input int p);
        int acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (p < acc + (dur_tab[i] + 1) * TD) return p - acc;
            acc += (dur_tab[i] + 1) * TD;
        end
        return 0;
    endfunction

    function automatic int low_key_freq(input logic [11:0] k);
        for (int i = 0; i < 12; i++) begin
            if (k[i]) return freq_tab[i];
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        bit adv;
        int st;
        adv = 1'b0;
        if (!rst_n) begin
            playing = 1'b0;
            pos = 0;
        end else if (stop) begin
            playing = 1'b0;
            pos = 0;
        end else if (key_req == 12'd0) begin
            if (!playing) begin
                if (play_start) begin
                    playing = 1'b1;
                    pos = 0;
                    adv = 1'b1;
                end
            end else begin
                pos++;
                adv = 1'b1;
                if (pos == song_len()) begin
                    pos = 0;
                    if (!loop_en) begin
                        playing = 1'b0;
                        adv = 1'b0;
                    end
                end
            end
        end
        st = step_of(pos);
        e_busy = playing;
        e_step = playing ? st : 0;
        if (rst_n && key_req != 12'd0) begin
            e_src = 1;
            e_freq = low_key_freq(key_req);
            e_strobe = 0;
        end else begin
            e_src = 0;
            e_freq = (playing && off_of(pos) < dur_tab[st] * TD) ? freq_tab[note_tab[st]] : 0;
            e_strobe = (adv && off_of(pos) == 0 && note_tab[st] < 12) ? 1 : 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_freq_out", 32'(freq_out), 32'(e_freq));
            check("model_src_key", 32'(src_key), 32'(e_src));
            check("model_busy", 32'(busy), 32'(e_busy));
            check("model_step_idx", 32'(step_idx), 32'(e_step));
            check("model_note_strobe", 32'(note_strobe), 32'(e_strobe));
        end
    end

    int strobe_cnt = 0;
    always @(negedge clk) if (chk_en && note_strobe === 1'b1) strobe_cnt++;

    task automatic start_pulse();
        play_start = 1'b1;
        @(negedge clk);
        play_start = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        int cnt261;
        rst_n = 1'b0;
        play_start = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        key_req = 12'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_freq", 32'(freq_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full song without looping
        strobe_cnt = 0;
        start_pulse();
        check("start_freq", 32'(freq_out), 32'd261);
        check("start_strobe", 32'(note_strobe), 32'd1);
        repeat (8) @(negedge clk);
        check("gap0_freq", 32'(freq_out), 32'd0);
        repeat (4) @(negedge clk);
        check("step1_freq", 32'(freq_out), 32'd293);
        repeat (90) @(negedge clk);
        check("song_end_busy", 32'(busy), 32'd0);
        check("song_strobes", 32'(strobe_cnt), 32'd7);

        // Looping wraps to step 0
        loop_en = 1'b1;
        start_pulse();
        repeat (99) @(negedge clk);
        check("loop_pre_step", 32'(step_idx), 32'd7);
        @(negedge clk);
        check("loop_step", 32'(step_idx), 32'd0);
        check("loop_freq", 32'(freq_out), 32'd261);
        check("loop_strobe", 32'(note_strobe), 32'd1);
        loop_en = 1'b0;
        stop_pulse();
        check("loop_stop_busy", 32'(busy), 32'd0);

        // Key pause during step 0
        start_pulse();
        cnt261 = (freq_out == 12'd261) ? 1 : 0;
        @(negedge clk);
        if (freq_out == 12'd261) cnt261++;
        key_req = 12'h210;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("key_freq", 32'(freq_out), 32'd330);
            check("key_src", 32'(src_key), 32'd1);
        end
        key_req = 12'd0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (freq_out == 12'd261) cnt261++;
        end
        check("key_resume_total", 32'(cnt261), 32'd8);
        stop_pulse();

        // Stop wins over play_start in step 3
        start_pulse();
        repeat (38) @(negedge clk);
        check("pre_stop_step", 32'(step_idx), 32'd3);
        stop = 1'b1;
        play_start = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        play_start = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_step", 32'(step_idx), 32'd0);
        check("stop_freq", 32'(freq_out), 32'd0);

        // Reset during step 5, then restart
        start_pulse();
        repeat (62) @(negedge clk);
        check("pre_reset_step", 32'(step_idx), 32'd5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_freq", 32'(freq_out), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_step", 32'(step_idx), 32'd0);
        start_pulse();
        check("restart_freq", 32'(freq_out), 32'd261);

        // play_start while busy is ignored
        repeat (20) @(negedge clk);
        start_pulse();
        repeat (3) @(negedge clk);
        check("busy_play_freq", 32'(freq_out), 32'd330);
        check("busy_play_step", 32'(step_idx), 32'd2);
        stop_pulse();

        // Keys in IDLE
        key_req = 12'h800;
        @(negedge clk);
        check("idle_key_b", 32'(freq_out), 32'd494);
        check("idle_key_busy", 32'(busy), 32'd0);
        key_req = 12'h003;
        @(negedge clk);
        check("idle_key_c", 32'(freq_out), 32'd261);
        key_req = 12'd0;
        @(negedge clk);
        check("idle_release_freq", 32'(freq_out), 32'd0);
        check("idle_release_src", 32'(src_key), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
